ologic_tx_sequencer: RTL and testbench
======================================

Name: ologic_tx_sequencer

Overview:
- Downstream consumer of the OLOGIC bitslip aligner; feeds the OLOGIC serializer data/tristate inputs in the gsclk_ol domain.
- Holds all write traffic until the aligner reports alignment complete (align_ol_ready_n low), then waits a settle interval.
- Buffers PHY write words in a small FIFO and emits framed bursts with programmable OE preamble/postamble and an idle pattern between bursts.
- Drops back to the alignment wait, and flushes the FIFO, whenever the aligner re-enters alignment.

Parameters:
- DW, 16, data word width presented to the serializer.
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 words (8).
- START_LVL, 4, FIFO level that starts a burst even with no s_last buffered; range 1..2**DEPTH_LOG2.
- SETTLE_CYC, 8, cycles after align_ol_ready_n falls before link_up; range 0..255.
- PRE_CYC, 1, OE preamble cycles before the first data word; range 1..15.
- POST_CYC, 1, OE postamble cycles after the last data word; range 0..15.
- IDLE_PAT, {DW{1'b0}}, value driven on ol_data whenever no data word is presented.

Ports:
- gsclk_ol  in  1  clock; all logic is in this domain.
- rst  in  1  asynchronous, active-high reset.
- align_ol_ready_n  in  1  from the aligner; 1 = alignment in progress, 0 = aligned.
- s_valid  in  1  write word valid.
- s_data  in  DW  write word.
- s_last  in  1  marks the final word of a burst.
- s_ready  out  1  FIFO accepts a word this cycle; a word transfers when s_valid & s_ready.
- ol_data  out  DW  registered data to the serializer.
- ol_oe  out  1  registered output enable to the OLOGIC tristate; 1 = drive.
- link_up  out  1  1 in IDLE, PRE, BURST and POST.
- underrun  out  1  sticky flag; FIFO ran empty mid-burst.
- fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset values: ol_data=IDLE_PAT, ol_oe=0, link_up=0, underrun=0, s_ready=0, fifo_level=0, last_cnt=0, state=ALIGN.
- FIFO and handshake:
  - s_ready = link_up & (fifo_level != 2**DEPTH_LOG2).
  - A push and a pop in the same cycle are both honoured; the level is unchanged.
  - last_cnt counts buffered words that have s_last set. It increments on a push with s_last and decrements on a pop of a word with s_last.
- States:
  - ALIGN: ol_oe=0, ol_data=IDLE_PAT.
    - Exit to SETTLE when align_ol_ready_n is sampled 0; load the settle counter with SETTLE_CYC.
    - SETTLE_CYC=0 goes straight to IDLE.
  - SETTLE: decrement the counter each cycle; go to IDLE on the edge where the counter reaches 0. link_up rises on entry to IDLE.
  - IDLE: ol_oe=0.
    - Start condition: last_cnt>0 or fifo_level>=START_LVL.
    - On the start condition go to PRE; ol_oe=1 from that edge.
  - PRE: ol_oe=1, ol_data=IDLE_PAT for exactly PRE_CYC cycles.
    - The edge ending PRE pops the FIFO head into ol_data and goes to BURST.
  - BURST: each edge pops the next head into ol_data.
    - After a popped word with s_last, the next edge goes to POST (ol_data=IDLE_PAT, ol_oe=1).
    - If POST_CYC=0, go directly to IDLE with ol_oe=0 and ol_data=IDLE_PAT.
    - If the FIFO is empty in BURST: ol_data=IDLE_PAT, ol_oe stays 1, underrun<=1, stay in BURST.
  - POST: ol_oe=1, ol_data=IDLE_PAT for POST_CYC cycles, then IDLE.
    - A pending start condition in the cycle of return to IDLE goes to PRE on the next edge, so there is at least one cycle with ol_oe=0 between bursts.
- Output timing: for a burst of N contiguous words, ol_oe is high for exactly PRE_CYC+N+POST_CYC cycles plus any underrun stall cycles.
- Re-align: align_ol_ready_n sampled 1 in any state other than ALIGN causes, on the next edge:
  - state=ALIGN, FIFO flushed (level=0, last_cnt=0);
  - ol_oe=0, ol_data=IDLE_PAT, link_up=0.
  - This event overrides a simultaneous push or pop; the pushed word is discarded.
- underrun clears only on rst.
- fifo_level is updated in the same edge as each push or pop.

Test Plan:
- Reset and alignment: rst high, then release; align_ol_ready_n=1 for 6 cycles, then 0, with SETTLE_CYC=8 -> link_up=0 and s_ready=0 until 8 cycles after the fall; ol_oe=0 and ol_data=0 throughout.
- Single-word burst: push 0xA5A5 with s_last at edge 0 (PRE_CYC=1, POST_CYC=1) -> ol_oe=1 from edge 1; ol_data=0xA5A5 at edge 2 only; ol_oe=0 at edge 4.
- Level-triggered start: push 0x0001..0x0004 with no s_last -> PRE entered after the 4th push; words appear in order; then push 0x0005 with s_last late -> underrun=1 and ol_data=IDLE_PAT during the gap; burst ends after 0x0005.
- Full FIFO: push 9 words with link_up=1 and the burst held off (START_LVL=8 start, words 1..9 pushed back-to-back) -> s_ready=0 at level 8; no word lost or duplicated; output order 1..8, then 9.
- Re-align mid-burst: raise align_ol_ready_n during BURST with 3 words buffered -> next edge ol_oe=0, fifo_level=0, link_up=0; after a fresh settle, no stale words are emitted.
- Simultaneous push/pop: sustained one-word-per-cycle stream during BURST -> fifo_level constant; ol_oe held continuously with no idle gaps.

Source files
------------

// File: rtl/ologic_tx_sequencer_if.sv
// Write-stream and serializer-feed bundle for the OLOGIC TX sequencer.
// The master side produces PHY write words and observes the serializer feed;
// the slave side is the sequencer itself.
interface ologic_tx_sequencer_if #(
    parameter int DW = 16
) ();
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] ol_data;
    logic          ol_oe;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready,
        input  ol_data,
        input  ol_oe
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready,
        output ol_data,
        output ol_oe
    );
endinterface

// File: rtl/ologic_tx_sequencer.sv
// OLOGIC TX sequencer: waits for bitslip alignment plus a settle interval,
// buffers write words in a small FIFO and frames them into OE-qualified bursts
// with preamble/postamble. Any return to alignment aborts and flushes.
module ologic_tx_sequencer #(
    parameter int            DW         = 16,
    parameter int            DEPTH_LOG2 = 3,
    parameter int            START_LVL  = 4,
    parameter int            SETTLE_CYC = 8,
    parameter int            PRE_CYC    = 1,
    parameter int            POST_CYC   = 1,
    parameter logic [DW-1:0] IDLE_PAT   = {DW{1'b0}}
) (
    input  logic                  gsclk_ol,
    input  logic                  rst,
    input  logic                  i_align_ol_ready_n,
    ologic_tx_sequencer_if.slave  bus,
    output logic                  o_link_up,
    output logic                  o_underrun,
    output logic [DEPTH_LOG2:0]   o_fifo_level
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam int                  PTR_W    = DEPTH_LOG2;
    localparam int                  LVL_W    = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]    START_L  = LVL_W'(START_LVL);
    localparam logic [LVL_W-1:0]    LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [7:0]          SETTLE_L = 8'(SETTLE_CYC);
    localparam logic [3:0]          PRE_L    = 4'(PRE_CYC - 1);
    localparam logic [3:0]          POST_L   = 4'(POST_CYC - 1);

    typedef enum logic [2:0] {
        ST_ALIGN,
        ST_SETTLE,
        ST_IDLE,
        ST_PRE,
        ST_BURST,
        ST_POST
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_settle_cnt;
    logic [7:0]          w_settle_next;
    logic [3:0]          r_phase_cnt;
    logic [3:0]          w_phase_next;

    logic [DW-1:0]       r_mem [DEPTH];
    logic                r_last_bits [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [LVL_W-1:0]    r_last_cnt;

    logic [DW-1:0]       r_ol_data;
    logic                r_ol_oe;
    logic                r_cur_last;
    logic                r_underrun;

    logic                w_link_up;
    logic                w_full;
    logic                w_empty;
    logic                w_s_ready;
    logic                w_realign;
    logic                w_push;
    logic                w_pop;
    logic                w_pop_last;
    logic                w_start;
    logic                w_oe_next;
    logic                w_underrun_set;
    logic                w_flush;

    assign w_link_up  = (r_state == ST_IDLE) || (r_state == ST_PRE) ||
                        (r_state == ST_BURST) || (r_state == ST_POST);
    assign w_full     = (r_level == FULL_LVL);
    assign w_empty    = (r_level == '0);
    assign w_s_ready  = w_link_up && !w_full;
    // A re-alignment request wins over any traffic in the same cycle.
    assign w_realign  = i_align_ol_ready_n && (r_state != ST_ALIGN);
    assign w_push     = bus.s_valid && w_s_ready && !w_realign;
    assign w_pop_last = r_last_bits[r_rd_ptr];
    assign w_start    = (r_last_cnt != '0) || (r_level >= START_L);

    // Next-state, counters and output-enable decode for the framing FSM.
    always_comb begin
        w_state_next   = r_state;
        w_settle_next  = r_settle_cnt;
        w_phase_next   = r_phase_cnt;
        w_oe_next      = r_ol_oe;
        w_pop          = 1'b0;
        w_underrun_set = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            ST_ALIGN: begin
                w_oe_next = 1'b0;
                if (!i_align_ol_ready_n) begin
                    w_settle_next = SETTLE_L;
                    w_state_next  = (SETTLE_CYC == 0) ? ST_IDLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_settle_next = r_settle_cnt - 8'd1;
                if (r_settle_cnt <= 8'd1) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_oe_next = 1'b0;
                if (w_start) begin
                    w_state_next = ST_PRE;
                    w_phase_next = PRE_L;
                    w_oe_next    = 1'b1;
                end
            end
            ST_PRE: begin
                w_oe_next = 1'b1;
                if (r_phase_cnt == 4'd0) begin
                    w_state_next = ST_BURST;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_underrun_set = 1'b1;
                    end
                end else begin
                    w_phase_next = r_phase_cnt - 4'd1;
                end
            end
            ST_BURST: begin
                w_oe_next = 1'b1;
                if (r_cur_last) begin
                    // The word on the pins closed the burst.
                    if (POST_CYC == 0) begin
                        w_state_next = ST_IDLE;
                        w_oe_next    = 1'b0;
                    end else begin
                        w_state_next = ST_POST;
                        w_phase_next = POST_L;
                    end
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                end else begin
                    // Starved mid-burst: keep driving the idle pattern.
                    w_underrun_set = 1'b1;
                end
            end
            ST_POST: begin
                w_oe_next = 1'b1;
                if (r_phase_cnt == 4'd0) begin
                    w_state_next = ST_IDLE;
                    w_oe_next    = 1'b0;
                end else begin
                    w_phase_next = r_phase_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = ST_ALIGN;
                w_oe_next    = 1'b0;
            end
        endcase
        if (w_realign) begin
            w_state_next   = ST_ALIGN;
            w_oe_next      = 1'b0;
            w_pop          = 1'b0;
            w_underrun_set = 1'b0;
            w_flush        = 1'b1;
        end
    end

    // FSM state, counters, registered serializer outputs and sticky underrun.
    always_ff @(posedge gsclk_ol or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ALIGN;
            r_settle_cnt <= 8'd0;
            r_phase_cnt  <= 4'd0;
            r_ol_data    <= IDLE_PAT;
            r_ol_oe      <= 1'b0;
            r_cur_last   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
            r_phase_cnt  <= w_phase_next;
            r_ol_data    <= w_pop ? r_mem[r_rd_ptr] : IDLE_PAT;
            r_ol_oe      <= w_oe_next;
            r_cur_last   <= w_pop ? w_pop_last : 1'b0;
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and count of buffered burst-terminating words.
    always_ff @(posedge gsclk_ol or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_last_cnt <= '0;
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_last_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            case ({w_push && bus.s_last, w_pop && w_pop_last})
                2'b10:   r_last_cnt <= r_last_cnt + LVL_ONE;
                2'b01:   r_last_cnt <= r_last_cnt - LVL_ONE;
                default: r_last_cnt <= r_last_cnt;
            endcase
        end
    end

    // Data storage; read side is registered through r_ol_data.
    always_ff @(posedge gsclk_ol) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.s_data;
        end
    end

    // Per-entry last flags, kept in flops so a pop can update last_cnt at once.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_last_bits
            always_ff @(posedge gsclk_ol or posedge rst) begin
                if (rst) begin
                    r_last_bits[gi] <= 1'b0;
                end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_last_bits[gi] <= bus.s_last;
                end
            end
        end
    endgenerate

    assign bus.s_ready   = w_s_ready;
    assign bus.ol_data   = r_ol_data;
    assign bus.ol_oe     = r_ol_oe;
    assign o_link_up     = w_link_up;
    assign o_underrun    = r_underrun;
    assign o_fifo_level  = r_level;

endmodule

// File: tb/tb_ologic_tx_sequencer.sv
// Directed bench for ologic_tx_sequencer: a per-cycle vector table for the
// single-word burst plus hand-written multi-cycle sequences. A second
// instance with START_LVL=8 exercises the full-FIFO case.
module tb_ologic_tx_sequencer;
    localparam int DW = 16;

    logic       gsclk_ol = 1'b0;
    logic       rst;
    logic       align_n;
    logic       align_b;
    logic       link_up, underrun, link_b, underrun_b;
    logic [3:0] level, level_b;

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];

    ologic_tx_sequencer_if #(.DW(DW)) bus_a ();
    ologic_tx_sequencer_if #(.DW(DW)) bus_b ();

    always #5 gsclk_ol = ~gsclk_ol;

    ologic_tx_sequencer #(.DW(DW)) u_dut (
        .gsclk_ol           (gsclk_ol),
        .rst                (rst),
        .i_align_ol_ready_n (align_n),
        .bus                (bus_a),
        .o_link_up          (link_up),
        .o_underrun         (underrun),
        .o_fifo_level       (level)
    );

    ologic_tx_sequencer #(.DW(DW), .START_LVL(8)) u_dut8 (
        .gsclk_ol           (gsclk_ol),
        .rst                (rst),
        .i_align_ol_ready_n (align_b),
        .bus                (bus_b),
        .o_link_up          (link_b),
        .o_underrun         (underrun_b),
        .o_fifo_level       (level_b)
    );

    // Capture every data word presented on the pins, mid-cycle.
    always @(negedge gsclk_ol) begin
        if (bus_a.ol_oe && bus_a.ol_data != 16'h0000) q_a.push_back(bus_a.ol_data);
        if (bus_b.ol_oe && bus_b.ol_data != 16'h0000) q_b.push_back(bus_b.ol_data);
    end

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        last;
        logic        exp_oe;
        logic [15:0] exp_data;
        logic [3:0]  exp_level;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge gsclk_ol);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  oe_cnt, rises, budget;
        bit  prev_oe, accepted, rdy_now, oe_seen;

        // single-word burst, one entry per clock edge (edge 0 = push)
        vecs[0] = '{1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 4'd1, 1'b1};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'd1, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 4'd0, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1};

        rst = 1'b1; align_n = 1'b1; align_b = 1'b1;
        bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.s_last = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.s_last = 1'b0;

        // ---- reset and alignment
        repeat (3) tick();
        check("rst_oe",      32'(bus_a.ol_oe), 0);
        check("rst_data",    32'(bus_a.ol_data), 0);
        check("rst_link",    32'(link_up), 0);
        check("rst_ready",   32'(bus_a.s_ready), 0);
        check("rst_level",   32'(level), 0);
        check("rst_underrun",32'(underrun), 0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("align_link", 32'(link_up), 0);
            check("align_oe",   32'(bus_a.ol_oe), 0);
        end
        align_n = 1'b0; align_b = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            $display("settle edge %0d: link_up=%0d s_ready=%0d", k, link_up, bus_a.s_ready);
            check("settle_link",  32'(link_up), 32'(k == 9));
            check("settle_ready", 32'(bus_a.s_ready), 32'(k == 9));
            check("settle_oe",    32'(bus_a.ol_oe), 0);
            check("settle_data",  32'(bus_a.ol_data), 0);
        end

        // ---- single-word burst from the vector table
        for (int i = 0; i < 6; i++) begin
            bus_a.s_valid = vecs[i].valid;
            bus_a.s_data  = vecs[i].data;
            bus_a.s_last  = vecs[i].last;
            tick();
            $display("vec %0d: oe=%0d data=%h level=%0d ready=%0d",
                     i, bus_a.ol_oe, bus_a.ol_data, level, bus_a.s_ready);
            check("vec_oe",    32'(bus_a.ol_oe),   32'(vecs[i].exp_oe));
            check("vec_data",  32'(bus_a.ol_data), 32'(vecs[i].exp_data));
            check("vec_level", 32'(level),         32'(vecs[i].exp_level));
            check("vec_ready", 32'(bus_a.s_ready), 32'(vecs[i].exp_ready));
        end
        check("single_underrun", 32'(underrun), 0);

        // ---- level-triggered start and underrun
        q_a.delete();
        for (int w = 1; w <= 4; w++) begin
            bus_a.s_valid = 1'b1; bus_a.s_data = 16'(w); bus_a.s_last = 1'b0;
            tick();
            $display("push a %h level=%0d oe=%0d", bus_a.s_data, level, bus_a.ol_oe);
            check("lvl_push_oe",    32'(bus_a.ol_oe), 0);
            check("lvl_push_level", 32'(level), 32'(w));
        end
        bus_a.s_valid = 1'b0;
        tick();
        check("lvl_pre_oe",   32'(bus_a.ol_oe), 1);
        check("lvl_pre_data", 32'(bus_a.ol_data), 0);
        for (int w = 1; w <= 4; w++) begin
            tick();
            check("lvl_word", 32'(bus_a.ol_data), 32'(w));
            check("lvl_word_oe", 32'(bus_a.ol_oe), 1);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gap_data", 32'(bus_a.ol_data), 0);
            check("gap_oe",   32'(bus_a.ol_oe), 1);
            check("gap_underrun", 32'(underrun), 1);
        end
        bus_a.s_valid = 1'b1; bus_a.s_data = 16'h0005; bus_a.s_last = 1'b1;
        tick();
        bus_a.s_valid = 1'b0; bus_a.s_last = 1'b0;
        tick();
        check("late_word", 32'(bus_a.ol_data), 32'h0005);
        tick();
        check("late_post_oe",   32'(bus_a.ol_oe), 1);
        check("late_post_data", 32'(bus_a.ol_data), 0);
        tick();
        check("late_end_oe", 32'(bus_a.ol_oe), 0);
        check("lvl_count", 32'(q_a.size()), 5);
        for (int w = 1; w <= 5; w++) check("lvl_order", 32'(q_a[w-1]), 32'(w));

        // ---- full FIFO on the START_LVL=8 instance
        q_b.delete();
        for (int w = 1; w <= 9; w++) begin
            bus_b.s_valid = 1'b1; bus_b.s_data = 16'(w); bus_b.s_last = (w == 9);
            accepted = 1'b0;
            budget = 0;
            while (!accepted && budget < 20) begin
                rdy_now = bus_b.s_ready;
                tick();
                budget++;
                if (rdy_now) accepted = 1'b1;
            end
            $display("push b %h accepted=%0d level=%0d", bus_b.s_data, accepted, level_b);
            check("full_accept", 32'(accepted), 1);
            if (w == 8) begin
                check("full_level", 32'(level_b), 8);
                check("full_ready", 32'(bus_b.s_ready), 0);
            end
        end
        bus_b.s_valid = 1'b0; bus_b.s_last = 1'b0;
        repeat (20) tick();
        check("full_end_oe",    32'(bus_b.ol_oe), 0);
        check("full_end_level", 32'(level_b), 0);
        check("full_count",     32'(q_b.size()), 9);
        for (int w = 1; w <= 9; w++) check("full_order", 32'(q_b[w-1]), 32'(w));
        check("full_underrun", 32'(underrun_b), 0);

        // ---- re-align mid-burst
        for (int w = 0; w < 7; w++) begin
            bus_a.s_valid = 1'b1; bus_a.s_data = 16'(32'h11 + w); bus_a.s_last = 1'b0;
            tick();
        end
        bus_a.s_valid = 1'b0;
        budget = 0;
        while (!(level == 4'd3 && bus_a.ol_oe) && budget < 20) begin
            tick();
            budget++;
        end
        check("realign_setup", 32'(level == 4'd3 && bus_a.ol_oe), 1);
        align_n = 1'b1;
        bus_a.s_valid = 1'b1; bus_a.s_data = 16'h0099;
        tick();
        bus_a.s_valid = 1'b0;
        $display("realign: oe=%0d level=%0d link_up=%0d", bus_a.ol_oe, level, link_up);
        check("realign_oe",    32'(bus_a.ol_oe), 0);
        check("realign_data",  32'(bus_a.ol_data), 0);
        check("realign_level", 32'(level), 0);
        check("realign_link",  32'(link_up), 0);
        check("realign_ready", 32'(bus_a.s_ready), 0);
        repeat (2) tick();
        align_n = 1'b0;
        repeat (9) tick();
        check("resettle_link",  32'(link_up), 1);
        check("resettle_level", 32'(level), 0);
        q_a.delete();
        oe_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus_a.ol_oe) oe_seen = 1'b1;
        end
        check("stale_oe",    32'(oe_seen), 0);
        check("stale_words", 32'(q_a.size()), 0);

        // ---- sustained stream: push and pop every cycle
        q_a.delete();
        oe_cnt = 0; rises = 0; prev_oe = 1'b0;
        for (int w = 0; w < 12; w++) begin
            bus_a.s_valid = 1'b1; bus_a.s_data = 16'(32'h21 + w); bus_a.s_last = (w == 11);
            tick();
            if (bus_a.ol_oe) oe_cnt++;
            if (bus_a.ol_oe && !prev_oe) rises++;
            prev_oe = bus_a.ol_oe;
            if (w >= 5) check("stream_level", 32'(level), 5);
        end
        bus_a.s_valid = 1'b0; bus_a.s_last = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus_a.ol_oe) oe_cnt++;
            if (bus_a.ol_oe && !prev_oe) rises++;
            prev_oe = bus_a.ol_oe;
        end
        $display("stream: oe_cycles=%0d oe_rises=%0d words=%0d", oe_cnt, rises, q_a.size());
        check("stream_oe_cycles", 32'(oe_cnt), 14);
        check("stream_oe_rises",  32'(rises), 1);
        check("stream_count",     32'(q_a.size()), 12);
        for (int w = 0; w < 12; w++) check("stream_order", 32'(q_a[w]), 32'h21 + 32'(w));
        check("stream_end_level", 32'(level), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
